// File: rtl/fp16_pkg.sv
// Shared definitions for the FP16 operand path: loader FSM states, frame length
// and FPU op-select width.
package fp16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FRAME_BYTES = 5;
  localparam int OP_W        = 4;
  localparam int CNT_W       = $clog2(FRAME_BYTES);

endpackage

// File: rtl/fp16_operand_loader_sync_edge.sv
// Strobe synchronizer with registered rising-edge detect. A strobe that is already
// high when reset releases is ignored until it has been seen low.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_vld;
  logic                   r_prev;
  logic                   r_armed;
  logic                   r_rise;

  // r_vld tracks which sync stages hold real samples since reset release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync  <= '0;
      r_vld   <= '0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], d};
      r_vld   <= {r_vld[SYNC_STAGES-2:0], 1'b1};
      r_prev  <= r_sync[SYNC_STAGES-1];
      r_armed <= r_armed | (r_vld[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES-1]);
      r_rise  <= r_armed & r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign q_rise = r_rise;

endmodule

// File: rtl/fp16_operand_loader.sv
// Collects a 5-byte frame (A hi/lo, B hi/lo, op) from an async strobed byte bus
// and presents num1/num2/op to the FPU with a one-cycle start pulse.
//
//   state | meaning
//   IDLE  | waiting for a frame-start byte (count 0)
//   LOAD  | frame partially received (count 1..4)
//   DONE  | outputs just updated, start high for this cycle
module fp16_operand_loader
  import fp16_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [9:0]      data_in,
  output logic [15:0]     num1,
  output logic [15:0]     num2,
  output logic [OP_W-1:0] op,
  output logic            start,
  output logic            busy,
  output logic            frame_err
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_a_hi, r_a_lo, r_b_hi, r_b_lo;
  logic             w_ev, w_fs, w_last;
  logic             w_err_nxt, w_done_nxt, w_busy_nxt;
  logic [7:0]       w_byte;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clock  (clock),
    .reset  (reset),
    .d      (data_in[8]),
    .q_rise (w_ev)
  );

  assign w_byte = data_in[7:0];
  assign w_fs   = data_in[9];
  assign w_last = (r_cnt == CNT_W'(FRAME_BYTES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A frame-start byte always restarts; DONE falls through to IDLE behaviour
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_ev) begin
      if (w_fs) begin
        w_state_nxt = LOAD;
        w_cnt_nxt   = CNT_W'(1);
      end else if (r_state == LOAD) begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end else begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    end else if (r_state == DONE) begin
      w_state_nxt = IDLE;
    end
  end

  always_comb begin
    w_err_nxt  = w_ev & ((w_fs & (r_cnt != '0)) | (~w_fs & (r_state != LOAD)));
    w_done_nxt = (w_state_nxt == DONE);
    w_busy_nxt = (w_state_nxt == LOAD);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a_hi <= '0;
      r_a_lo <= '0;
      r_b_hi <= '0;
      r_b_lo <= '0;
    end else if (w_ev && w_fs) begin
      r_a_hi <= w_byte;
    end else if (w_ev && r_state == LOAD) begin
      case (r_cnt)
        CNT_W'(1): r_a_lo <= w_byte;
        CNT_W'(2): r_b_hi <= w_byte;
        CNT_W'(3): r_b_lo <= w_byte;
        default:   ;
      endcase
    end
  end

  // Outputs drive the FPU directly, so they change only when the frame completes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      num1      <= '0;
      num2      <= '0;
      op        <= '0;
      start     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      start     <= w_done_nxt;
      busy      <= w_busy_nxt;
      frame_err <= w_err_nxt;
      if (w_done_nxt) begin
        num1 <= {r_a_hi, r_a_lo};
        num2 <= {r_b_hi, r_b_lo};
        op   <= w_byte[OP_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fp16_operand_loader.sv
// Directed bench for fp16_operand_loader: nominal, restart, stray, long strobe,
// reset mid-frame, back-to-back frames.
module tb_fp16_operand_loader;

  localparam int SYNC = 2;

  logic        clock;
  logic        reset;
  logic [9:0]  data_in;
  logic [15:0] num1, num2;
  logic [3:0]  op;
  logic        start, busy, frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  int n_ferr = 0;
  int start_cyc = -1;
  int s0, e0, t5;

  fp16_operand_loader #(.SYNC_STAGES(SYNC)) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .num1      (num1),
    .num2      (num2),
    .op        (op),
    .start     (start),
    .busy      (busy),
    .frame_err (frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (start) begin
      n_start++;
      start_cyc = cyc;
    end
    if (frame_err) n_ferr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send_byte(input logic [7:0] b, input logic fs, input int hi, input int lo);
    data_in = {fs, 1'b1, b};
    repeat (hi) @(posedge clock);
    #1;
    data_in[8] = 1'b0;
    repeat (lo) @(posedge clock);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    data_in = '0;
    wait_cyc(5);
    chk("rst_num1", num1, 16'h0000);
    chk("rst_num2", num2, 16'h0000);
    chk("rst_op", op, 4'h0);
    chk("rst_ctl", {start, busy, frame_err}, 3'b000);
    reset = 1'b1;
    wait_cyc(6);

    // nominal frame
    s0 = n_start; e0 = n_ferr;
    send_byte(8'h3C, 1'b1, 3, 3);
    chk("nom_busy_b1", busy, 1'b1);
    send_byte(8'h00, 1'b0, 3, 3);
    send_byte(8'h40, 1'b0, 3, 3);
    send_byte(8'h00, 1'b0, 3, 3);
    chk("nom_busy_b4", busy, 1'b1);
    chk("nom_hold_num1", num1, 16'h0000);
    t5 = cyc;
    send_byte(8'h01, 1'b0, 3, 3);
    chk("nom_num1", num1, 16'h3C00);
    chk("nom_num2", num2, 16'h4000);
    chk("nom_op", op, 4'h1);
    chk("nom_starts", n_start - s0, 1);
    chk("nom_latency", start_cyc - t5, SYNC + 2);
    chk("nom_busy_end", busy, 1'b0);
    chk("nom_ferr", n_ferr - e0, 0);

    // restart mid-frame
    s0 = n_start; e0 = n_ferr;
    send_byte(8'h3C, 1'b1, 3, 3);
    send_byte(8'h00, 1'b0, 3, 3);
    send_byte(8'hC0, 1'b1, 3, 3);
    chk("rst_frame_err", n_ferr - e0, 1);
    send_byte(8'h00, 1'b0, 3, 3);
    send_byte(8'h3C, 1'b0, 3, 3);
    send_byte(8'h00, 1'b0, 3, 3);
    send_byte(8'h02, 1'b0, 3, 3);
    chk("restart_num1", num1, 16'hC000);
    chk("restart_num2", num2, 16'h3C00);
    chk("restart_op", op, 4'h2);
    chk("restart_starts", n_start - s0, 1);
    chk("restart_ferr_total", n_ferr - e0, 1);

    // stray byte in IDLE
    s0 = n_start; e0 = n_ferr;
    send_byte(8'h55, 1'b0, 3, 3);
    chk("stray_ferr", n_ferr - e0, 1);
    chk("stray_num1", num1, 16'hC000);
    chk("stray_op", op, 4'h2);
    chk("stray_busy", busy, 1'b0);
    chk("stray_starts", n_start - s0, 0);

    // long strobe
    s0 = n_start; e0 = n_ferr;
    send_byte(8'h3C, 1'b1, 50, 5);
    send_byte(8'h00, 1'b0, 50, 5);
    send_byte(8'h40, 1'b0, 50, 5);
    send_byte(8'h00, 1'b0, 50, 5);
    send_byte(8'h01, 1'b0, 50, 5);
    chk("long_num1", num1, 16'h3C00);
    chk("long_num2", num2, 16'h4000);
    chk("long_op", op, 4'h1);
    chk("long_starts", n_start - s0, 1);
    chk("long_ferr", n_ferr - e0, 0);

    // reset after byte 3, strobe held high through reset release
    s0 = n_start; e0 = n_ferr;
    send_byte(8'h41, 1'b1, 3, 3);
    send_byte(8'h23, 1'b0, 3, 3);
    send_byte(8'h45, 1'b0, 3, 3);
    chk("mid_busy_pre", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_num1", num1, 16'h0000);
    chk("mid_num2", num2, 16'h0000);
    chk("mid_op", op, 4'h0);
    chk("mid_busy", busy, 1'b0);
    data_in = {1'b0, 1'b1, 8'h55};
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(10);
    chk("hi_at_release_ctl", {busy, frame_err}, 2'b00);
    chk("hi_at_release_ferr", n_ferr - e0, 0);
    chk("mid_no_start", n_start - s0, 0);
    data_in[8] = 1'b0;
    wait_cyc(5);
    send_byte(8'h41, 1'b1, 3, 3);
    send_byte(8'h23, 1'b0, 3, 3);
    send_byte(8'h45, 1'b0, 3, 3);
    send_byte(8'h67, 1'b0, 3, 3);
    send_byte(8'h0A, 1'b0, 3, 3);
    chk("post_rst_num1", num1, 16'h4123);
    chk("post_rst_num2", num2, 16'h4567);
    chk("post_rst_op", op, 4'hA);
    chk("post_rst_starts", n_start - s0, 1);

    // back-to-back: next frame's first strobe rises during DONE
    s0 = n_start; e0 = n_ferr;
    send_byte(8'h12, 1'b1, 3, 3);
    send_byte(8'h34, 1'b0, 3, 3);
    send_byte(8'h56, 1'b0, 3, 3);
    send_byte(8'h78, 1'b0, 3, 3);
    send_byte(8'h05, 1'b0, 2, 2);
    chk("b2b_in_done", start, 1'b1);
    chk("b2b_first_num1", num1, 16'h1234);
    send_byte(8'h9A, 1'b1, 3, 3);
    send_byte(8'hBC, 1'b0, 3, 3);
    send_byte(8'hDE, 1'b0, 3, 3);
    send_byte(8'hF0, 1'b0, 3, 3);
    send_byte(8'h07, 1'b0, 3, 3);
    chk("b2b_starts", n_start - s0, 2);
    chk("b2b_num1", num1, 16'h9ABC);
    chk("b2b_num2", num2, 16'hDEF0);
    chk("b2b_op", op, 4'h7);
    chk("b2b_ferr", n_ferr - e0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_operand_loader.md
FP16_OPERAND_LOADER -- requirements
Module: fp16_operand_loader

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the strobe synchronizer depth (legal values 2..4).
REQ-002 SHALL have port clock  input  1  single system clock; all flops rise-edge triggered.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port data_in  input  10  [7:0] byte, [8] strobe (asynchronous to clock), [9] frame-start qualifier.
REQ-005 SHALL have port num1  output  16  operand A, FP16 bit pattern.
REQ-006 SHALL have port num2  output  16  operand B, FP16 bit pattern.
REQ-007 SHALL have port op  output  4  FPU operation select.
REQ-008 SHALL have port start  output  1  one-cycle pulse: num1/num2/op are valid and newly updated.
REQ-009 SHALL have port busy  output  1  high while a frame is partially received.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-011 SHALL pass data_in[8] through SYNC_STAGES flops; a byte event is the cycle where the synchronized strobe is 1 and was 0 the cycle before.
REQ-012 SHALL sample data_in[7:0] and data_in[9] directly in the byte-event cycle; the off-chip source holds both stable from strobe rise for at least SYNC_STAGES+2 cycles.
REQ-013 SHALL capture exactly one byte per strobe rising edge, regardless of how long the strobe stays high.
REQ-014 SHALL define a frame as 5 bytes in this order: A[15:8], A[7:0], B[15:8], B[7:0], op byte (op = bits [3:0], bits [7:4] ignored).
REQ-015 SHALL use a byte counter (0..4) and states IDLE (count 0), LOAD (count 1..4), DONE.
REQ-016 SHALL, on a byte event with data_in[9]=1, store the byte as A[15:8], set count to 1 and enter LOAD; if count was nonzero, frame_err SHALL pulse in the next cycle (restart).
REQ-017 SHALL, on a byte event with data_in[9]=0 in IDLE, discard the byte and pulse frame_err in the next cycle.
REQ-018 SHALL, on a byte event with data_in[9]=0 in LOAD, store the byte in the slot selected by count and increment count; the fifth byte moves the state to DONE.
REQ-019 SHALL hold partial bytes in shadow registers; num1, num2 and op update together, only in the DONE cycle.
REQ-020 SHALL assert start for exactly the DONE cycle, then return to IDLE; start fires SYNC_STAGES+2 cycles after the 5th strobe rise reaches the first sync flop.
REQ-021 SHALL hold num1, num2 and op unchanged between frames.
REQ-022 SHALL drive busy = (state == LOAD), registered.
REQ-023 SHALL accept a byte event in the DONE cycle: it is processed as if from IDLE.

Reset
REQ-024 SHALL, while reset=0, asynchronously force num1=0x0000, num2=0x0000, op=0x0, start=0, busy=0, frame_err=0, count=0, state IDLE, all sync flops 0.
REQ-025 SHALL discard any partial frame on reset mid-frame; no start pulse is produced for it.
REQ-026 SHALL NOT treat a strobe that is high at reset release as a byte event until it has gone low and high again.

Structure
REQ-027 SHALL place the state enum (IDLE, LOAD, DONE), FRAME_BYTES=5 and the op width constant in shared package fp16_pkg, which is also used by the FPU and the output stage.
REQ-028 SHALL implement the synchronizer and edge detector as sub-module sync_edge (parameter SYNC_STAGES; ports clock, reset, d, q_rise).
REQ-029 SHALL connect num1/num2/op/start directly to the FPU-side num1/num2/op/start nets, with no added pipeline stage.

Verification
REQ-030 SHALL cover a nominal frame: bytes 3C(fs=1),00,40,00,01 -> num1=0x3C00, num2=0x4000, op=0x1, one start pulse at the REQ-020 latency, busy high only during bytes 1-4.
REQ-031 SHALL cover restart: 3C(fs=1),00,C0(fs=1),00,3C,00,02 -> frame_err one pulse; num1=0xC000, num2=0x3C00, op=0x2.
REQ-032 SHALL cover a stray byte: 55(fs=0) in IDLE -> frame_err pulse, outputs unchanged, busy=0, no start.
REQ-033 SHALL cover a long strobe: strobe held 50 cycles per byte -> identical result to REQ-030, exactly one capture per byte.
REQ-034 SHALL cover reset mid-frame: reset asserted after byte 3 -> all outputs 0 immediately; a full new frame then completes normally.
REQ-035 SHALL cover back-to-back frames: second frame's first edge lands in the DONE cycle -> both start pulses occur, and the second frame's values are presented.
